regfile_sequencer: RTL
======================

# regfile_sequencer

Instruction-driven initiator for the dual-write, dual-read 16×16-bit register file. Accepts one 16-bit register-register instruction per handshake, reads its operands through the file's two read ports, computes a single ALU result, and writes back through write port A, or through both write ports for SWAP. It sits between the lab control/test logic and the register file, which it drives directly.

## Interface
- DATA_W, 16, datapath and register width (fixed at 16; the register file is 16-bit)
- ADDR_W, 4, register address width (16 registers)
- CLK  in  1  clock, all state changes on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- INSTR  in  16  instruction {OP[15:12], RD[11:8], RS[7:4], RT[3:0]}
- INSTR_VALID  in  1  instruction present
- INSTR_READY  out  1  sequencer can accept; high only in IDLE
- RAA / RAB  out  4  read addresses A/B to register file
- REA / REB  out  1  read enables A/B
- RDA / RDB  in  16  read data A/B (combinational from file)
- WAA / WDA / WEA  out  4/16/1  write port A address/data/enable
- WAB / WDB / WEB  out  4/16/1  write port B address/data/enable
- RESULT  out  16  last computed result, held
- FLAG_Z / FLAG_C  out  1  zero / carry-borrow of last flag-updating op
- DONE  out  1  one-cycle pulse in the WRITE cycle
- ERR  out  1  one-cycle pulse with DONE for undefined opcode

## Operation
- FSM: IDLE -> READ -> EXEC -> WRITE -> IDLE. No other transitions except reset.
- IDLE: INSTR_READY=1. On INSTR_VALID&INSTR_READY at an edge, latch INSTR and go to READ. INSTR is ignored otherwise.
- READ: RAA=RS, RAB=RT, REA=REB=1, except LDI, which holds REA=REB=0. At the edge, capture RDA->OPA and RDB->OPB.
- EXEC: compute RESULT (registered) and update flags; go to WRITE.
- WRITE: assert write enables per opcode and pulse DONE; go to IDLE.
- Opcodes (arithmetic mod 2^16):
  - 0 ADD: RD<=OPA+OPB. C=carry out.
  - 1 SUB: RD<=OPA-OPB. C=borrow (OPA<OPB unsigned).
  - 2 AND, 3 OR, 4 XOR: RD<=OPA op OPB. C=0.
  - 5 NOT: RD<=~OPA. C=0.
  - 6 SHL: RD<=OPA<<OPB[3:0]. C=0.
  - 7 SHR: RD<=OPA>>OPB[3:0], logical. C=0.
  - 8 LDI: RD<={8'h00,RS,RT}. C=0.
  - 9 SWAP: WEA with WAA=RS, WDA=OPB; WEB with WAB=RT, WDB=OPA. RESULT, Z and C unchanged. RS==RT writes the same data to the same address on both ports (legal, no-op in effect).
  - 10 MOV: RD<=OPA. C=0.
  - 11-15: no write; DONE and ERR pulse; RESULT and flags unchanged.
- FLAG_Z = (RESULT==0) for every op that updates RESULT.
- Write enable is asserted only in WRITE. WEB is asserted only for SWAP. When not enabled, write address/data outputs are 0.
- REA/REB are 0 outside READ; RAA/RAB are 0 outside READ.
- RD==RS or RD==RT is legal: operands are captured before writeback.

## Timing
- Reset (async assert): state=IDLE; all outputs 0 including INSTR_READY, RESULT, flags, DONE, ERR.
- INSTR_READY rises on the first rising edge after RST_N deasserts.
- Accept at edge N: READ during cycle N..N+1, EXEC N+1..N+2, WRITE/DONE N+2..N+3. The register file commits at edge N+3.
- Throughput: one instruction per 4 cycles. With INSTR_VALID held high, the next accept occurs at edge N+4 (INSTR_READY high in cycle N+3..N+4).
- Reset asserted in any state: immediate return to IDLE. No WEA/WEB pulse is emitted for the aborted instruction; DONE does not fire.

## Test plan
- LDI r1,0xFF, then ADD r3=r1+r1 -> r3=0x01FE, Z=0, C=0. DONE high exactly in the 3rd cycle after each accept; INSTR_READY low for 3 cycles.
- r1=0xFFFF (LDI 0xFF, SHL by r2=8, OR with r1), r2=0x0001, ADD r4=r1+r2 -> r4=0x0000, Z=1, C=1. SUB r5=r2-r1 -> r5=0x0002, C=1.
- r6=0x0012, r7=0x0034, SWAP RS=6 RT=7 -> WEA and WEB asserted in the same cycle; readback r6=0x0034, r7=0x0012; flags unchanged.
- Opcode 0xC -> DONE and ERR pulse together, WEA=WEB=0, RESULT unchanged. ADD with RD==RS (r1=r1+r2) -> uses the pre-write r1.
- INSTR_VALID held high for 3 instructions -> accepts at 4-cycle spacing, three DONE pulses, no instruction dropped or duplicated.
- Drop RST_N during EXEC -> all outputs 0 asynchronously, no write to the target register (readback shows old value), INSTR_READY returns 1 edge after release.

Source files
------------

// File: rtl/regfile_sequencer_if.sv
// rtl/regfile_sequencer_if.sv - instruction handshake and register-file port bundle
interface regfile_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [15:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] raa;
  logic [ADDR_W-1:0] rab;
  logic              rea;
  logic              reb;
  logic [DATA_W-1:0] rda;
  logic [DATA_W-1:0] rdb;
  logic [ADDR_W-1:0] waa;
  logic [DATA_W-1:0] wda;
  logic              wea;
  logic [ADDR_W-1:0] wab;
  logic [DATA_W-1:0] wdb;
  logic              web;

  // master: the sequencer side (accepts instructions, drives the file)
  modport master (
    input  instr, instr_valid, rda, rdb,
    output instr_ready, raa, rab, rea, reb, waa, wda, wea, wab, wdb, web
  );

  modport slave (
    output instr, instr_valid, rda, rdb,
    input  instr_ready, raa, rab, rea, reb, waa, wda, wea, wab, wdb, web
  );
endinterface

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - four-state instruction sequencer driving a dual-port register file
module regfile_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  regfile_sequencer_if.master bus,
  output logic [DATA_W-1:0]  result_o,
  output logic               flag_z_o,
  output logic               flag_c_o,
  output logic               done_o,
  output logic               err_o
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_LDI  = 4'd8;
  localparam logic [3:0] OP_SWAP = 4'd9;
  localparam logic [3:0] OP_MOV  = 4'd10;

  state_t            state_q, state_d;
  logic              started_q;
  logic [15:0]       instr_q, instr_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              z_q, z_d;
  logic              c_q, c_d;

  logic [3:0]        op;
  logic [ADDR_W-1:0] rd, rs, rt;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_upd;

  assign op  = instr_q[15:12];
  assign rd  = instr_q[11:8];
  assign rs  = instr_q[7:4];
  assign rt  = instr_q[3:0];
  assign sum = {1'b0, opa_q} + {1'b0, opb_q};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      started_q <= 1'b0;
      instr_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      instr_q   <= instr_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      z_q       <= z_d;
      c_q       <= c_d;
    end
  end

  // SWAP and undefined opcodes leave RESULT and flags untouched
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_upd = 1'b1;
    case (op)
      OP_ADD:  {alu_c, alu_res} = sum;
      OP_SUB:  begin alu_res = opa_q - opb_q; alu_c = (opa_q < opb_q); end
      OP_AND:  alu_res = opa_q & opb_q;
      OP_OR:   alu_res = opa_q | opb_q;
      OP_XOR:  alu_res = opa_q ^ opb_q;
      OP_NOT:  alu_res = ~opa_q;
      OP_SHL:  alu_res = opa_q << opb_q[3:0];
      OP_SHR:  alu_res = opa_q >> opb_q[3:0];
      OP_LDI:  alu_res = DATA_W'(instr_q[7:0]);
      OP_MOV:  alu_res = opa_q;
      default: alu_upd = 1'b0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    opa_d           = opa_q;
    opb_d           = opb_q;
    result_d        = result_q;
    z_d             = z_q;
    c_d             = c_q;
    bus.instr_ready = 1'b0;
    bus.raa         = '0;
    bus.rab         = '0;
    bus.rea         = 1'b0;
    bus.reb         = 1'b0;
    bus.waa         = '0;
    bus.wda         = '0;
    bus.wea         = 1'b0;
    bus.wab         = '0;
    bus.wdb         = '0;
    bus.web         = 1'b0;
    done_o          = 1'b0;
    err_o           = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.instr_ready = started_q;
        if (started_q && bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        bus.raa = rs;
        bus.rab = rt;
        bus.rea = (op != OP_LDI);
        bus.reb = (op != OP_LDI);
        opa_d   = bus.rda;
        opb_d   = bus.rdb;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (alu_upd) begin
          result_d = alu_res;
          z_d      = (alu_res == '0);
          c_d      = alu_c;
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
        if (op == OP_SWAP) begin
          bus.wea = 1'b1;
          bus.waa = rs;
          bus.wda = opb_q;
          bus.web = 1'b1;
          bus.wab = rt;
          bus.wdb = opa_q;
        end else if (op <= OP_MOV) begin
          bus.wea = 1'b1;
          bus.waa = rd;
          bus.wda = result_q;
        end else begin
          err_o = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign result_o = result_q;
  assign flag_z_o = z_q;
  assign flag_c_o = c_q;

endmodule
